serial_alu32: RTL and testbench
===============================

# serial_alu32

Bit-serial 32-bit ALU sequencer for the MIPS datapath. It accepts a full operation (operands plus 3-bit ALU op), then walks a single 1-bit ALU slice from bit 0 to bit 31, one bit per clock. A carry register chains the bits together. At the MSB it derives carry-out, overflow and the SLT set bit, then presents a 32-bit result with a one-cycle done pulse. It serves as the area-reduced drop-in for the parallel ALU in multi-cycle builds, and as the sequential driving end of the 1-bit slice protocol.

## Interface
- No parameters; width fixed at 32, op encoding fixed.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  32  operand A; latched on accepted start.
- b  input  32  operand B; latched on accepted start.
- op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  registered, exactly one-cycle pulse when the result is valid.
- result  output  32  final result; valid from done and held until the next accepted start.
- c_out  output  1  carry out of bit 31.
- overflow  output  1  signed overflow (V).
- set  output  1  SLT set bit: sum[31] XOR V.
- zero  output  1  result == 0; valid with result.

## Operation
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- States:
  - IDLE.
  - RUN: 32 cycles, bit counter 0..31.
  - SLTFIX: 1 cycle, SLT only.
  - DONE: 1 cycle.
- Transitions:
  - IDLE → RUN on start=1. This latches a, b and op, clears the counter, and loads carry = 1 for SUB/SLT, else 0.
  - RUN with cnt<31 → RUN, cnt+1.
  - RUN with cnt=31 → SLTFIX if op=111, else DONE.
  - SLTFIX → DONE.
  - DONE → IDLE.
- Per RUN cycle:
  - Slice inputs are a_sh[0] and b_eff = b_sh[0] XOR binv, where binv = (op==110 or op==111).
  - Bit result: AND → a&b_eff; OR → a|b_eff; ADD/SUB/SLT → sum = a^b_eff^carry.
  - The bit is shifted into result from the MSB end; a_sh and b_sh shift right.
  - carry ← majority(a, b_eff, carry).
- At cnt=31, registered in the same edge:
  - carry_into_31 is the carry value before that edge.
  - c_out = new carry; overflow = carry_into_31 XOR c_out; set = sum31 XOR overflow.
  - These three apply to ADD/SUB/SLT only; for AND/OR they are 0.
- SLTFIX: result ← {31'b0, set}. c_out and overflow keep the subtract values.
- zero is computed from the final result and registered by the edge entering DONE.
- Undefined ops (011, 100, 101): full 32-cycle sequence; result, c_out, overflow, set and zero are all 0.
- start while busy is ignored, with no queuing. Inputs a, b and op are don't-care after acceptance.
- Reset, at any time including mid-RUN: immediately to IDLE. All outputs, counter, carry and shift registers are cleared to 0.

## Timing
- Accepted-start edge = E0.
- Non-SLT ops:
  - Bit i is computed on edge E(i+1).
  - State is DONE after E32; done=1 in the cycle between E32 and E33.
  - Latency is 32 cycles from start.
- SLT:
  - SLTFIX follows E32.
  - done=1 after E33; latency 33 cycles.
- busy:
  - Rises after E0.
  - Falls on the edge leaving DONE, i.e. the same edge on which done falls.
  - A start asserted in the cycle done is high is ignored.
  - The earliest next accept is the cycle after done. Back-to-back throughput is one op per 34 cycles (35 for SLT).
- Before the first operation and after reset: result=0, zero=0, done=0, busy=0.
- result and all flags stay stable between done and the next accepted start.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001:
  - done exactly 32 cycles after start.
  - result=0x80000000, overflow=1, c_out=0, set=0, zero=0.
- SUB a=5, b=5:
  - result=0, zero=1, c_out=1, overflow=0.
- SUB a=0, b=1:
  - result=0xFFFFFFFF, c_out=0, overflow=0.
- SLT a=0x80000000, b=1:
  - result=1, set=1, overflow=1, done 33 cycles after start.
- SLT a=0x7FFFFFFF, b=0xFFFFFFFF:
  - result=0.
- AND a=0xF0F0F0F0, b=0x0FF00FF0:
  - result=0x00F000F0, c_out=0, overflow=0.
- OR on the same operands:
  - result=0xFFF0FFF0.
- op=101:
  - result=0 and zero=0 after 32 cycles.
- Robustness:
  - Pulse start with a new op during RUN: it is ignored and the first result is unchanged.
  - Assert reset at cnt=10: busy=0, result=0 and done=0 immediately.
  - A fresh ADD 3+4 then returns 7 after 32 cycles.

Source files
------------

// File: rtl/serial_alu32.sv
// serial_alu32: bit-serial 32-bit ALU sequencer.
// Walks one 1-bit ALU slice from bit 0 to bit 31, one bit per clock, chaining a carry register.
// It derives carry-out, overflow and the SLT set bit at the MSB.
// It then presents a registered 32-bit result with a one-cycle done pulse.
module serial_alu32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        c_out,
    output logic        overflow,
    output logic        set,
    output logic        zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SLTFIX = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   acc;
    logic [2:0]     op_q;
    logic [CW-1:0]  cnt;
    logic           carry;

    logic           binv;
    logic           arith;
    logic           valid_op;
    logic           a_bit;
    logic           b_eff;
    logic           sum_bit;
    logic           carry_nxt;
    logic           bit_res;
    logic [W-1:0]   acc_nxt;
    logic           c_nxt;
    logic           ov_nxt;
    logic           set_nxt;

    // 1-bit ALU slice and MSB flag derivation for the current bit position
    always_comb begin
        binv      = (op_q == OP_SUB) || (op_q == OP_SLT);
        arith     = (op_q == OP_ADD) || binv;
        valid_op  = arith || (op_q == OP_AND) || (op_q == OP_OR);
        a_bit     = a_sh[0];
        b_eff     = b_sh[0] ^ binv;
        sum_bit   = a_bit ^ b_eff ^ carry;
        carry_nxt = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
        bit_res   = 1'b0;
        case (op_q)
            OP_AND:                 bit_res = a_bit & b_eff;
            OP_OR:                  bit_res = a_bit | b_eff;
            OP_ADD, OP_SUB, OP_SLT: bit_res = sum_bit;
            default:                bit_res = 1'b0;
        endcase
        acc_nxt = {bit_res, acc[W-1:1]};
        // Flags only meaningful at bit 31 and only for arithmetic ops
        c_nxt   = arith & carry_nxt;
        ov_nxt  = arith & (carry ^ carry_nxt);
        set_nxt = arith & (sum_bit ^ carry ^ carry_nxt);
    end

    // Sequencer FSM with registered datapath and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            set      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_q  <= op;
                        acc   <= '0;
                        cnt   <= '0;
                        carry <= (op == OP_SUB) || (op == OP_SLT);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_nxt;
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        c_out    <= c_nxt;
                        overflow <= ov_nxt;
                        set      <= set_nxt;
                        if (op_q == OP_SLT) begin
                            state <= SLTFIX;
                        end else begin
                            result <= acc_nxt;
                            zero   <= valid_op && (acc_nxt == '0);
                            done   <= 1'b1;
                            state  <= FINISH;
                        end
                    end
                end
                SLTFIX: begin
                    result <= {{(W - 1){1'b0}}, set};
                    zero   <= ~set;
                    done   <= 1'b1;
                    state  <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu32.sv
// tb_serial_alu32: scoreboard bench for the bit-serial ALU sequencer.
module tb_serial_alu32;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        s;
        logic        z;
        int unsigned lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        c_out;
    logic        overflow;
    logic        set;
    logic        zero;

    int n_checks;
    int n_fail;
    exp_t exp_q[$];

    serial_alu32 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .set      (set),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference ALU model, written from the op encoding rather than the slice walk
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] top);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] s;
        logic        arith;
        e     = '0;
        arith = (top == 3'b010) || (top == 3'b110) || (top == 3'b111);
        bb    = (top == 3'b010) ? tb_v : ~tb_v;
        s     = {1'b0, ta} + {1'b0, bb} + ((top == 3'b010) ? 33'd0 : 33'd1);
        if (arith) begin
            e.c = s[32];
            e.v = (ta[31] == bb[31]) && (s[31] != ta[31]);
            e.s = s[31] ^ e.v;
        end
        case (top)
            3'b000:         e.r = ta & tb_v;
            3'b001:         e.r = ta | tb_v;
            3'b010, 3'b110: e.r = s[31:0];
            3'b111:         e.r = {31'b0, e.s};
            default:        e.r = 32'd0;
        endcase
        e.z   = (top == 3'b011 || top == 3'b100 || top == 3'b101) ? 1'b0 : (e.r == 32'd0);
        e.lat = (top == 3'b111) ? 33 : 32;
        return e;
    endfunction

    // Issue one op, optionally poke start mid-run, then pop and score the result
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] top,
                          input bit poke);
        exp_t e;
        int   n;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        op    = top;
        start = 1'b1;
        exp_q.push_back(model(ta, tb_v, top));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom_range(7, 0));
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 100) begin
            if (poke && n == 5) begin
                start = 1'b1;
                op    = 3'b001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!done) begin
            check("done_timeout", 32'(done), 32'd1);
            return;
        end
        check("latency", 32'(n), 32'(e.lat));
        check("result", result, e.r);
        check("c_out", 32'(c_out), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.v));
        check("set", 32'(set), 32'(e.s));
        check("zero", 32'(zero), 32'(e.z));
        check("busy_at_done", 32'(busy), 32'd1);
        // start during the done cycle must be ignored
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("no_accept_in_done", 32'(busy), 32'd0);
        check("result_held", result, e.r);
        check("zero_held", 32'(zero), 32'(e.z));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {29'd0, c_out, overflow, set}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b0);
        run_op(32'd5, 32'd5, 3'b110, 1'b0);
        run_op(32'd0, 32'd1, 3'b110, 1'b0);
        run_op(32'h80000000, 32'd1, 3'b111, 1'b0);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0);
        run_op(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 1'b0);
        run_op(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 1'b0);
        run_op(32'h12345678, 32'h9ABCDEF0, 3'b101, 1'b0);
        run_op(32'h0000FFFF, 32'h00000001, 3'b010, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(7, 0));
            run_op($urandom, $urandom, rop, 1'b0);
        end

        // Reset mid-run at cnt=10
        @(negedge clk);
        a     = 32'hDEADBEEF;
        b     = 32'h01234567;
        op    = 3'b010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_result", result, 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd3, 32'd4, 3'b010, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
